// File: rtl/jtflane_pcm_arb.sv
`default_nettype none
// ============================================================================
// Module   : jtflane_pcm_arb
// Purpose  : Round-robin arbiter and one-word read cache serving the four
//            007232 PCM ROM ports (A/B/C/D) from a single SDRAM read port.
// Revision : 1.0 - initial release
// ============================================================================
module jtflane_pcm_arb #(
    parameter logic [21:0] BA_A = 22'h00_0000,
    parameter logic [21:0] BA_B = 22'h01_0000,
    parameter logic [21:0] BA_C = 22'h02_0000,
    parameter logic [21:0] BA_D = 22'h02_0000
)(
    input  logic        clk,
    input  logic        rstn,
    input  logic [16:0] pcma_addr,
    input  logic [16:0] pcmb_addr,
    input  logic [18:0] pcmc_addr,
    input  logic [18:0] pcmd_addr,
    input  logic        pcma_cs,
    input  logic        pcmb_cs,
    input  logic        pcmc_cs,
    input  logic        pcmd_cs,
    output logic [7:0]  pcma_dout,
    output logic [7:0]  pcmb_dout,
    output logic [7:0]  pcmc_dout,
    output logic [7:0]  pcmd_dout,
    output logic        pcma_ok,
    output logic        pcmb_ok,
    output logic        pcmc_ok,
    output logic        pcmd_ok,
    output logic [21:0] sdram_addr,
    output logic        sdram_rd,
    input  logic        sdram_ack,
    input  logic        sdram_rdy,
    input  logic [15:0] sdram_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_gnt;
    logic [1:0]  w_gnt_nxt;
    logic [1:0]  r_last;
    logic [17:0] r_ptag;
    logic [17:0] w_ptag_nxt;
    logic        w_rd_nxt;
    logic [21:0] w_addr_nxt;
    logic        w_fill;

    // Per-channel cache line; A/B tags are stored zero-extended to 18 bits
    logic [17:0] r_tag  [4];
    logic [15:0] r_data [4];
    logic [3:0]  r_valid;

    logic [17:0] w_word [4];
    logic [7:0]  w_dout [4];
    logic [3:0]  w_cs;
    logic [3:0]  w_lsb;
    logic [3:0]  w_hit;
    logic [3:0]  w_miss;
    logic        w_any;
    logic [1:0]  w_pick;
    logic [21:0] w_base;

    assign w_word[0] = {2'b00, pcma_addr[16:1]};
    assign w_word[1] = {2'b00, pcmb_addr[16:1]};
    assign w_word[2] = pcmc_addr[18:1];
    assign w_word[3] = pcmd_addr[18:1];

    assign w_cs  = {pcmd_cs, pcmc_cs, pcmb_cs, pcma_cs};
    assign w_lsb = {pcmd_addr[0], pcmc_addr[0], pcmb_addr[0], pcma_addr[0]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            assign w_hit[gi]  = w_cs[gi] & r_valid[gi] & (r_tag[gi] == w_word[gi]);
            assign w_miss[gi] = w_cs[gi] & ~w_hit[gi];
            assign w_dout[gi] = w_lsb[gi] ? r_data[gi][15:8] : r_data[gi][7:0];
        end
    endgenerate

    assign pcma_ok   = w_hit[0];
    assign pcmb_ok   = w_hit[1];
    assign pcmc_ok   = w_hit[2];
    assign pcmd_ok   = w_hit[3];
    assign pcma_dout = w_dout[0];
    assign pcmb_dout = w_dout[1];
    assign pcmc_dout = w_dout[2];
    assign pcmd_dout = w_dout[3];

    // Round-robin pick: first missing channel after the last one served
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_last;
        for (int k = 1; k <= 4; k++) begin
            if (!w_any && w_miss[r_last + 2'(k)]) begin
                w_any  = 1'b1;
                w_pick = r_last + 2'(k);
            end
        end
    end

    // Region base address of the picked channel
    always_comb begin
        case (w_pick)
            2'd0:    w_base = BA_A;
            2'd1:    w_base = BA_B;
            2'd2:    w_base = BA_C;
            default: w_base = BA_D;
        endcase
    end

    // Next-state logic: grant, wait for ack, then wait for data
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptag_nxt  = r_ptag;
        w_rd_nxt    = sdram_rd;
        w_addr_nxt  = sdram_addr;
        w_fill      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_REQ;
                    w_gnt_nxt   = w_pick;
                    w_ptag_nxt  = w_word[w_pick];
                    w_rd_nxt    = 1'b1;
                    w_addr_nxt  = w_base + {4'd0, w_word[w_pick]};
                end
            end
            S_REQ: begin
                if (sdram_ack) begin
                    w_rd_nxt = 1'b0;
                    // Data may come back together with the ack
                    if (sdram_rdy) begin
                        w_fill      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (sdram_rdy) begin
                    w_fill      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sequencer registers and SDRAM request outputs; last=3 so A wins first
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_gnt      <= 2'd0;
            r_ptag     <= 18'd0;
            r_last     <= 2'd3;
            sdram_rd   <= 1'b0;
            sdram_addr <= 22'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_ptag     <= w_ptag_nxt;
            sdram_rd   <= w_rd_nxt;
            sdram_addr <= w_addr_nxt;
            if (w_fill) begin
                r_last <= r_gnt;
            end
        end
    end

    // Cache fill always uses the tag captured at grant time
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                r_tag[i]  <= 18'd0;
                r_data[i] <= 16'd0;
            end
        end else if (w_fill) begin
            r_valid[r_gnt] <= 1'b1;
            r_tag[r_gnt]   <= r_ptag;
            r_data[r_gnt]  <= sdram_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtflane_pcm_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtflane_pcm_arb
// Purpose  : Self-checking bench for jtflane_pcm_arb with a transaction-level
//            cache/arbiter model and an SDRAM responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtflane_pcm_arb;

    logic        clk;
    logic        rstn;
    logic [18:0] t_addr [4];
    logic [3:0]  t_cs;
    logic        sdram_ack;
    logic        sdram_rdy;
    logic [15:0] sdram_data;
    wire  [7:0]  pcma_dout, pcmb_dout, pcmc_dout, pcmd_dout;
    wire         pcma_ok, pcmb_ok, pcmc_ok, pcmd_ok;
    wire  [21:0] sdram_addr;
    wire         sdram_rd;
    wire  [3:0]  ok_v = {pcmd_ok, pcmc_ok, pcmb_ok, pcma_ok};

    jtflane_pcm_arb dut (
        .clk        (clk),
        .rstn       (rstn),
        .pcma_addr  (t_addr[0][16:0]),
        .pcmb_addr  (t_addr[1][16:0]),
        .pcmc_addr  (t_addr[2]),
        .pcmd_addr  (t_addr[3]),
        .pcma_cs    (t_cs[0]),
        .pcmb_cs    (t_cs[1]),
        .pcmc_cs    (t_cs[2]),
        .pcmd_cs    (t_cs[3]),
        .pcma_dout  (pcma_dout),
        .pcmb_dout  (pcmb_dout),
        .pcmc_dout  (pcmc_dout),
        .pcmd_dout  (pcmd_dout),
        .pcma_ok    (pcma_ok),
        .pcmb_ok    (pcmb_ok),
        .pcmc_ok    (pcmc_ok),
        .pcmd_ok    (pcmd_ok),
        .sdram_addr (sdram_addr),
        .sdram_rd   (sdram_rd),
        .sdram_ack  (sdram_ack),
        .sdram_rdy  (sdram_rdy),
        .sdram_data (sdram_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state (transaction level)
    bit          m_valid [4];
    logic [17:0] m_tag   [4];
    logic [15:0] m_data  [4];
    int          m_last;
    bit          m_busy;
    bit          m_wait;
    int          m_g;
    logic [17:0] m_ptag;
    logic [21:0] m_addr;

    // Stimulus / responder controls
    bit          rand_stim;
    bit          det_mode;
    int          det_lat;
    bit          fix_data;
    logic [15:0] det_data;
    bit          inc_c;
    bit          stray_en;
    bit          force_stray;
    int          wait_cnt;
    bit          prev_rd;
    logic [21:0] obs_addr_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] word_of(input int ch);
        if (ch < 2) return {2'b00, t_addr[ch][16:1]};
        return t_addr[ch][18:1];
    endfunction

    function automatic logic [21:0] base_of(input int ch);
        case (ch)
            0:       return 22'h000000;
            1:       return 22'h010000;
            default: return 22'h020000;
        endcase
    endfunction

    function automatic bit m_hit(input int ch);
        return t_cs[ch] && m_valid[ch] && (m_tag[ch] == word_of(ch));
    endfunction

    function automatic logic [7:0] exp_dout(input int ch);
        return t_addr[ch][0] ? m_data[ch][15:8] : m_data[ch][7:0];
    endfunction

    function automatic logic [7:0] dout_of(input int ch);
        case (ch)
            0:       return pcma_dout;
            1:       return pcmb_dout;
            2:       return pcmc_dout;
            default: return pcmd_dout;
        endcase
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < 4; ch++) begin
            m_valid[ch] = 1'b0;
            m_tag[ch]   = 18'd0;
            m_data[ch]  = 16'd0;
        end
        m_last = 3;
        m_busy = 1'b0;
        m_wait = 1'b0;
        m_g    = 0;
    endtask

    task automatic model_fill();
        m_data[m_g]  = sdram_data;
        m_tag[m_g]   = m_ptag;
        m_valid[m_g] = 1'b1;
        m_last       = m_g;
        m_busy       = 1'b0;
        m_wait       = 1'b0;
    endtask

    // Predicts the effect of the coming clock edge from the inputs now driven
    task automatic model_update();
        if (m_busy) begin
            if (!m_wait) begin
                if (sdram_ack) begin
                    if (sdram_rdy) model_fill();
                    else m_wait = 1'b1;
                end
            end else if (sdram_rdy) begin
                model_fill();
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int ch;
                ch = (m_last + k) % 4;
                if (!m_busy && t_cs[ch] && !m_hit(ch)) begin
                    m_busy = 1'b1;
                    m_wait = 1'b0;
                    m_g    = ch;
                    m_ptag = word_of(ch);
                    m_addr = base_of(ch) + {4'd0, m_ptag};
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int ch = 0; ch < 4; ch++) begin
            chk($sformatf("ok%0d", ch), 32'(ok_v[ch]), 32'(m_hit(ch)));
            chk($sformatf("dout%0d", ch), 32'(dout_of(ch)), 32'(exp_dout(ch)));
        end
        chk("sdram_rd", 32'(sdram_rd), 32'(m_busy && !m_wait));
        if (m_busy) chk("sdram_addr", 32'(sdram_addr), 32'(m_addr));
        if (sdram_rd && !prev_rd) obs_addr_q.push_back(sdram_addr);
        prev_rd = sdram_rd;
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic commit();
        if (rand_stim) begin
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 7) == 0) t_cs[ch] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 5) == 0) begin
                    if (ch < 2) t_addr[ch] = 19'($urandom_range(0, 15));
                    else t_addr[ch] = 19'($urandom_range(0, 15)) |
                                      (($urandom_range(0, 1) == 1) ? 19'h40000 : 19'h0);
                end
            end
        end
        if (inc_c && m_hit(2)) t_addr[2] = t_addr[2] + 19'd2;
        sdram_ack  = 1'b0;
        sdram_rdy  = 1'b0;
        sdram_data = fix_data ? det_data : 16'($urandom);
        if (m_busy && !m_wait) begin
            sdram_ack = det_mode ? 1'b1 : ($urandom_range(0, 2) == 0);
            if (sdram_ack) begin
                wait_cnt  = 0;
                sdram_rdy = det_mode ? (det_lat == 0) : ($urandom_range(0, 3) == 0);
            end
        end else if (m_busy) begin
            wait_cnt++;
            sdram_rdy = det_mode ? (wait_cnt >= det_lat) : ($urandom_range(0, 2) == 0);
        end else if (force_stray) begin
            sdram_rdy = 1'b1;
        end else if (stray_en) begin
            sdram_ack = ($urandom_range(0, 9) == 0);
            sdram_rdy = ($urandom_range(0, 9) == 0);
        end
        model_update();
    endtask

    task automatic step();
        tick();
        commit();
    endtask

    // Asserts reset just after an active edge and checks the immediate clear
    task automatic pulse_reset();
        @(posedge clk);
        #2;
        chk("pre_rst_rd", 32'(sdram_rd), 32'(m_busy && !m_wait));
        rstn = 1'b0;
        #1;
        chk("rst_rd", 32'(sdram_rd), 32'd0);
        chk("rst_addr", 32'(sdram_addr), 32'd0);
        for (int ch = 0; ch < 4; ch++) begin
            chk($sformatf("rst_ok%0d", ch), 32'(ok_v[ch]), 32'd0);
            chk($sformatf("rst_dout%0d", ch), 32'(dout_of(ch)), 32'd0);
        end
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        check_outputs();
        force_stray = 1'b1;
        commit();
        force_stray = 1'b0;
    endtask

    initial begin
        int n;
        rstn        = 1'b0;
        t_cs        = 4'd0;
        for (int ch = 0; ch < 4; ch++) t_addr[ch] = 19'd0;
        sdram_ack   = 1'b0;
        sdram_rdy   = 1'b0;
        sdram_data  = 16'd0;
        rand_stim   = 1'b0;
        det_mode    = 1'b1;
        det_lat     = 3;
        fix_data    = 1'b1;
        det_data    = 16'hBEEF;
        inc_c       = 1'b0;
        stray_en    = 1'b0;
        force_stray = 1'b0;
        wait_cnt    = 0;
        prev_rd     = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_rd", 32'(sdram_rd), 32'd0);
        chk("reset_addr", 32'(sdram_addr), 32'd0);
        check_outputs();
        rstn = 1'b1;

        // Single miss on A, data 3 cycles after ack, then a same-word hit
        t_cs[0]   = 1'b1;
        t_addr[0] = 19'h00005;
        commit();
        n = 0;
        while (m_busy && n < 50) begin step(); n++; end
        chk("t1_timeout", 32'(n < 50), 32'd1);
        tick();
        chk("t1_sdram_addr", 32'((obs_addr_q.size() > 0) ? obs_addr_q[0] : 22'h3FFFFF), 32'h000002);
        chk("t1_dout_hi", 32'(pcma_dout), 32'hBE);
        chk("t1_ok", 32'(pcma_ok), 32'd1);
        n = obs_addr_q.size();
        t_addr[0] = 19'h00004;
        commit();
        tick();
        chk("t1_dout_lo", 32'(pcma_dout), 32'hEF);
        chk("t1_ok_hit", 32'(pcma_ok), 32'd1);
        commit();
        step();
        chk("t1_no_new_req", 32'(obs_addr_q.size()), 32'(n));

        // Four simultaneous misses after reset: grants A, B, C, D
        tick();
        t_cs = 4'd0;
        commit();
        pulse_reset();
        det_mode = 1'b0;
        fix_data = 1'b0;
        obs_addr_q.delete();
        tick();
        t_addr[0] = 19'h00010;
        t_addr[1] = 19'h00020;
        t_addr[2] = 19'h00040;
        t_addr[3] = 19'h40100;
        t_cs      = 4'hF;
        commit();
        n = 0;
        while (!(m_hit(0) && m_hit(1) && m_hit(2) && m_hit(3)) && n < 400) begin step(); n++; end
        chk("t2_timeout", 32'(n < 400), 32'd1);
        tick();
        chk("t2_nreq", 32'(obs_addr_q.size()), 32'd4);
        if (obs_addr_q.size() >= 4) begin
            chk("t2_grant_a", 32'(obs_addr_q[0]), 32'h000008);
            chk("t2_grant_b", 32'(obs_addr_q[1]), 32'h010010);
            chk("t2_grant_c", 32'(obs_addr_q[2]), 32'h020020);
            chk("t2_grant_d", 32'(obs_addr_q[3]), 32'h040080);
        end
        chk("t2_ok_all", 32'(ok_v), 32'hF);
        commit();

        // C streams continuously; B must be served right after the current C fill
        tick();
        t_cs      = 4'b0100;
        t_addr[2] = 19'h00100;
        inc_c     = 1'b1;
        commit();
        repeat (30) step();
        n = 0;
        while (!(m_busy && m_g == 2) && n < 100) begin step(); n++; end
        chk("t3_c_busy_timeout", 32'(n < 100), 32'd1);
        tick();
        t_cs[1]   = 1'b1;
        t_addr[1] = 19'h00030;
        n = obs_addr_q.size();
        commit();
        begin
            int w = 0;
            while (obs_addr_q.size() <= n && w < 200) begin step(); w++; end
            chk("t3_timeout", 32'(w < 200), 32'd1);
        end
        chk("t3_b_next", 32'((obs_addr_q.size() > n) ? obs_addr_q[n] : 22'h3FFFFF), 32'h010018);
        inc_c = 1'b0;
        n = 0;
        while (m_busy && n < 100) begin step(); n++; end

        // Address changes while the fill is outstanding
        tick();
        t_cs = 4'd0;
        commit();
        pulse_reset();
        det_mode = 1'b1;
        det_lat  = 4;
        tick();
        t_cs      = 4'b0001;
        t_addr[0] = 19'h00100;
        commit();
        n = 0;
        while (!m_wait && n < 20) begin step(); n++; end
        tick();
        t_addr[0] = 19'h00300;
        commit();
        n = 0;
        while (m_busy && n < 20) begin step(); n++; end
        chk("t4_timeout", 32'(n < 20), 32'd1);
        tick();
        chk("t4_ok_stale", 32'(pcma_ok), 32'd0);
        commit();
        tick();
        chk("t4_rd", 32'(sdram_rd), 32'd1);
        chk("t4_new_addr", 32'(sdram_addr), 32'h000180);
        commit();
        tick();
        t_addr[0] = 19'h00100;
        commit();
        tick();
        chk("t4_tag_080", 32'(pcma_ok), 32'd1);
        commit();
        n = 0;
        while (m_busy && n < 20) begin step(); n++; end

        // ack and rdy in the same cycle
        det_lat = 0;
        tick();
        t_cs      = 4'b0011;
        t_addr[0] = 19'h00200;
        t_addr[1] = 19'h00202;
        n = obs_addr_q.size();
        commit();
        begin
            int w = 0;
            while (!(m_hit(0) && m_hit(1)) && w < 20) begin step(); w++; end
            chk("t5_timeout", 32'(w < 20), 32'd1);
        end
        tick();
        chk("t5_ok", 32'(ok_v[1:0]), 32'h3);
        chk("t5_nreq", 32'(obs_addr_q.size() - n), 32'd2);
        commit();

        // Reset during REQ, then during WAIT, each followed by a stray rdy
        det_lat = 3;
        tick();
        t_cs      = 4'b0001;
        t_addr[0] = 19'h00400;
        commit();
        pulse_reset();
        n = 0;
        while (!m_wait && n < 20) begin step(); n++; end
        pulse_reset();
        tick();
        chk("t6_ok_a", 32'(pcma_ok), 32'd0);
        chk("t6_ok_all", 32'(ok_v), 32'd0);
        commit();

        // Randomized traffic with random SDRAM latencies and stray strobes
        det_mode  = 1'b0;
        fix_data  = 1'b0;
        rand_stim = 1'b1;
        stray_en  = 1'b1;
        for (int r = 0; r < 3; r++) begin
            repeat (1000) step();
            pulse_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
